// File: rtl/svcs_hs_rx_deframer.sv
// SVCS handshake receive deframer: decodes the 7-word transaction header and
// forwards the int payload words as a first/last-framed stream.
module svcs_hs_rx_deframer #(
  parameter int unsigned MAX_PAYLOAD = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [63:0]      hdr_trnx_type,
  output logic [63:0]      hdr_trnx_id,
  output logic [63:0]      hdr_data_type,
  output logic [31:0]      hdr_n_payloads,
  output logic             hdr_valid,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_first,
  output logic             m_last,
  output logic             len_err,
  output logic             halted,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned REM_W = 32;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [63:0]        trnx_type_d, trnx_id_d, data_type_d;
  logic [31:0]        n_payloads_d;
  logic               hdr_valid_d, len_err_d, halted_d;
  logic [CNT_W-1:0]   frame_cnt_d, err_cnt_d;

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HDR;
      idx_q          <= '0;
      rem_q          <= '0;
      first_q        <= 1'b0;
      hdr_trnx_type  <= '0;
      hdr_trnx_id    <= '0;
      hdr_data_type  <= '0;
      hdr_n_payloads <= '0;
      hdr_valid      <= 1'b0;
      len_err        <= 1'b0;
      halted         <= 1'b0;
      frame_cnt      <= '0;
      err_cnt        <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      rem_q          <= rem_d;
      first_q        <= first_d;
      hdr_trnx_type  <= trnx_type_d;
      hdr_trnx_id    <= trnx_id_d;
      hdr_data_type  <= data_type_d;
      hdr_n_payloads <= n_payloads_d;
      hdr_valid      <= hdr_valid_d;
      len_err        <= len_err_d;
      halted         <= halted_d;
      frame_cnt      <= frame_cnt_d;
      err_cnt        <= err_cnt_d;
    end
  end

  // Next-state, header decode and the combinational payload pass-through.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    first_d      = first_q;
    trnx_type_d  = hdr_trnx_type;
    trnx_id_d    = hdr_trnx_id;
    data_type_d  = hdr_data_type;
    n_payloads_d = hdr_n_payloads;
    hdr_valid_d  = 1'b0;
    len_err_d    = 1'b0;
    halted_d     = halted;
    frame_cnt_d  = frame_cnt;
    err_cnt_d    = err_cnt;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;
    m_first      = 1'b0;
    m_last       = 1'b0;

    case (state_q)
      ST_HDR: begin
        s_ready = !rst;
        if (s_valid && !rst) begin
          idx_d = idx_q + IDX_W'(1);
          case (idx_q)
            3'd0: trnx_type_d[31:0]  = s_data;
            3'd1: trnx_type_d[63:32] = s_data;
            3'd2: trnx_id_d[31:0]    = s_data;
            3'd3: trnx_id_d[63:32]   = s_data;
            3'd4: data_type_d[31:0]  = s_data;
            3'd5: data_type_d[63:32] = s_data;
            default: begin
              n_payloads_d = s_data;
              idx_d        = '0;
              hdr_valid_d  = 1'b1;
              if (s_data == 32'd0) begin
                frame_cnt_d = frame_cnt + CNT_W'(1);
              end else if (s_data[31]) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end else if (s_data <= 32'(MAX_PAYLOAD)) begin
                state_d = ST_PAY;
                rem_d   = s_data;
                first_d = 1'b1;
              end else begin
                state_d   = ST_DROP;
                rem_d     = s_data;
                len_err_d = 1'b1;
                err_cnt_d = err_cnt + CNT_W'(1);
              end
            end
          endcase
        end
      end

      ST_PAY: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_data;
        m_first = first_q;
        m_last  = (rem_q == REM_W'(1));
        if (s_valid && m_ready) begin
          rem_d   = rem_q - REM_W'(1);
          first_d = 1'b0;
          if (rem_q == REM_W'(1)) begin
            frame_cnt_d = frame_cnt + CNT_W'(1);
            state_d     = ST_HDR;
          end
        end
      end

      ST_DROP: begin
        s_ready = 1'b1;
        if (s_valid) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            frame_cnt_d = frame_cnt + CNT_W'(1);
            state_d     = ST_HDR;
          end
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_svcs_hs_rx_deframer.sv
// Randomized bench for svcs_hs_rx_deframer against a transaction-level model
// of expected headers, payload beats and counters.
module tb_svcs_hs_rx_deframer;

  localparam int unsigned MAXP = 4;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   hdr_trnx_type, hdr_trnx_id, hdr_data_type;
  logic [31:0]   hdr_n_payloads;
  logic          hdr_valid;
  logic [31:0]   m_data;
  logic          m_valid, m_ready, m_first, m_last;
  logic          len_err, halted;
  logic [CW-1:0] frame_cnt, err_cnt;

  always #5 clk = ~clk;

  svcs_hs_rx_deframer #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .hdr_trnx_type(hdr_trnx_type), .hdr_trnx_id(hdr_trnx_id),
    .hdr_data_type(hdr_data_type), .hdr_n_payloads(hdr_n_payloads),
    .hdr_valid(hdr_valid), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_first(m_first), .m_last(m_last), .len_err(len_err), .halted(halted),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic first; logic last; logic [31:0] data;} beat_t;
  typedef struct packed {logic [63:0] t; logic [63:0] i; logic [63:0] d; logic [31:0] n;} hdr_t;

  beat_t exp_beats[$];
  hdr_t  exp_hdrs[$];
  int    exp_frames   = 0;
  int    exp_errs     = 0;
  int    len_err_seen = 0;
  logic  exp_halted   = 1'b0;
  bit    gaps_en      = 1'b0;
  bit    stall_en     = 1'b0;

  // Output monitor: every visible beat and header pulse must match the model.
  always @(negedge clk) begin : mon
    hdr_t h;
    if (!rst) begin
      if (m_valid) begin
        check("m_valid_expected", 64'(exp_beats.size() != 0), 64'(1));
        if (exp_beats.size() != 0) begin
          check("m_data", 64'(m_data), 64'(exp_beats[0].data));
          check("m_first", 64'(m_first), 64'(exp_beats[0].first));
          check("m_last", 64'(m_last), 64'(exp_beats[0].last));
          check("s_ready_follows_m_ready", 64'(s_ready), 64'(m_ready));
          if (m_ready) void'(exp_beats.pop_front());
        end
      end
      if (hdr_valid) begin
        check("hdr_valid_expected", 64'(exp_hdrs.size() != 0), 64'(1));
        if (exp_hdrs.size() != 0) begin
          h = exp_hdrs.pop_front();
          check("hdr_trnx_type", hdr_trnx_type, h.t);
          check("hdr_trnx_id", hdr_trnx_id, h.i);
          check("hdr_data_type", hdr_data_type, h.d);
          check("hdr_n_payloads", 64'(hdr_n_payloads), 64'(h.n));
        end
      end
      if (len_err) len_err_seen++;
    end
  end

  function automatic logic rnd_ready();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Offer one word, with optional idle gaps, until it is accepted.
  task automatic push(input logic [31:0] w);
    int guard;
    while (gaps_en && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      m_ready = rnd_ready();
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    guard   = 0;
    forever begin
      m_ready = rnd_ready();
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        check("push_timeout", 64'(s_ready), 64'(1));
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] t, input logic [63:0] i, input logic [63:0] d,
                            input logic [31:0] n, input logic [31:0] base);
    hdr_t  h;
    beat_t b;
    h.t = t; h.i = i; h.d = d; h.n = n;
    exp_hdrs.push_back(h);
    if (n == 0) exp_frames++;
    else if (n[31]) exp_halted = 1'b1;
    else begin
      if (n <= MAXP) begin
        for (int k = 0; k < int'(n); k++) begin
          b.first = (k == 0);
          b.last  = (k == int'(n) - 1);
          b.data  = base + 32'(k);
          exp_beats.push_back(b);
        end
      end else exp_errs++;
      exp_frames++;
    end
    push(t[31:0]); push(t[63:32]);
    push(i[31:0]); push(i[63:32]);
    push(d[31:0]); push(d[63:32]);
    push(n);
    if (n != 0 && !n[31])
      for (int k = 0; k < int'(n); k++) push(base + 32'(k));
  endtask

  task automatic settle_and_check();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("frame_cnt", 64'(frame_cnt), 64'(exp_frames % (1 << CW)));
    check("err_cnt", 64'(err_cnt), 64'(exp_errs % (1 << CW)));
    check("len_err_pulses", 64'(len_err_seen), 64'(exp_errs));
    check("beats_outstanding", 64'(exp_beats.size()), 64'(0));
    check("hdrs_outstanding", 64'(exp_hdrs.size()), 64'(0));
    check("halted", 64'(halted), 64'(exp_halted));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_hdr_trnx_type", hdr_trnx_type, 64'(0));
    check("rst_hdr_trnx_id", hdr_trnx_id, 64'(0));
    check("rst_hdr_data_type", hdr_data_type, 64'(0));
    check("rst_hdr_n_payloads", 64'(hdr_n_payloads), 64'(0));
    check("rst_flags", 64'({hdr_valid, m_valid, m_first, m_last, len_err, halted}), 64'(0));
    check("rst_counters", 64'({frame_cnt, err_cnt}), 64'(0));
    @(posedge clk); #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    exp_beats.delete();
    exp_hdrs.delete();
    exp_frames   = 0;
    exp_errs     = 0;
    len_err_seen = 0;
    exp_halted   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    int r;
    logic [31:0] n;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    #1;
    do_reset();

    // Basic frame, no backpressure.
    send_frame(64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h1, 32'd3, 32'hA);
    settle_and_check();

    // Same frame with stalls and gaps.
    gaps_en = 1'b1; stall_en = 1'b1;
    send_frame(64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h1, 32'd3, 32'hA);
    settle_and_check();
    gaps_en = 1'b0; stall_en = 1'b0;

    // Empty frame followed back-to-back by a 2-word frame.
    send_frame(64'h11, 64'h22, 64'h33, 32'd0, 32'h0);
    send_frame(64'h44, 64'h55, 64'h66, 32'd2, 32'h100);
    settle_and_check();

    // Oversize drop, then a single-word frame.
    send_frame(64'h77, 64'h88, 64'h99, 32'd6, 32'h200);
    send_frame(64'hAA, 64'hBB, 64'hCC, 32'd1, 32'h55);
    settle_and_check();

    // Length boundaries: exactly MAXP and MAXP+1.
    send_frame(64'h1, 64'h2, 64'h3, 32'(MAXP), 32'h300);
    send_frame(64'h4, 64'h5, 64'h6, 32'(MAXP + 1), 32'h400);
    settle_and_check();

    // Negative count halts the receiver until reset.
    send_frame(64'hF0, 64'hF1, 64'hF2, 32'hFFFF_FFFF, 32'h0);
    settle_and_check();
    hi_cnt  = 0;
    s_valid = 1'b1;
    repeat (100) begin
      s_data = $urandom;
      @(negedge clk);
      if (s_ready) hi_cnt++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("halt_s_ready_cycles", 64'(hi_cnt), 64'(0));
    do_reset();
    send_frame(64'h123, 64'h456, 64'h789, 32'd1, 32'h9000);
    settle_and_check();

    // Reset in the middle of a header.
    push(32'hAAAA_0000); push(32'hBBBB_0000); push(32'hCCCC_0000); push(32'hDDDD_0000);
    do_reset();
    send_frame(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 64'h5, 32'd1, 32'h77);
    settle_and_check();

    // Random frames; enough of them to wrap the frame counter.
    for (int f = 0; f < 40; f++) begin
      gaps_en  = 1'($urandom_range(0, 1));
      stall_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 2) n = 32'd0;
      else if (r < 8) n = 32'($urandom_range(1, MAXP));
      else n = 32'($urandom_range(MAXP + 1, MAXP + 4));
      send_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, n, $urandom);
      if ($urandom_range(0, 2) == 0) settle_and_check();
    end
    settle_and_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
